// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory stage.
// Holds the register-file/data widths and the data-memory access FSM encoding.
package mips_pkg;

  localparam int REG_ADDR_W = 8;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  // Word accesses only; any set low address bit is an alignment fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake FSM with wait-cycle timeout.
// Tracks outstanding requests, flags misalignment/timeout, and ERR is sticky until reset.
module mem_access_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mem_op,
  input  logic       i_misaligned,
  input  logic       i_req,
  input  logic       i_ack,
  output mem_state_t o_state,
  output logic       o_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t       r_state;
  mem_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_err;

  // The counter holds the number of unacknowledged request cycles seen so far,
  // so the timeout fires after exactly TIMEOUT_CYCLES request cycles.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_mem_op && i_misaligned) begin
          w_next = ERR;
        end else if (i_req && !i_ack) begin
          if (r_cnt == CNT_LAST) begin
            w_next = ERR;
          end else begin
            w_next     = WAIT;
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (i_mem_op && i_misaligned) begin
          w_next = ERR;
        end else if (i_req && i_ack) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next = ERR;
        end else begin
          w_next     = WAIT;
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ERR: begin
        w_next = ERR;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= (w_next == ERR);
    end
  end

  assign o_state = r_state;
  assign o_err   = r_err;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a data-memory handshake.
// Stalls the front of the pipeline while a load/store waits for its acknowledge.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [DATA_W-1:0]     RS2_sw,
  input  logic [REG_ADDR_W-1:0] write_addr_IDEX,
  input  logic                  reg_write_IDEX,
  input  logic                  mem_read_IDEX,
  input  logic                  mem_write_IDEX,
  input  logic                  mem_to_reg_IDEX,
  output logic [DATA_W-1:0]     alu_res_EXMEM,
  output logic [REG_ADDR_W-1:0] write_addr_EXMEM,
  output logic                  reg_write_EXMEM,
  output logic [DATA_W-1:0]     write_data,
  output logic [REG_ADDR_W-1:0] write_addr_MEMWB,
  output logic                  reg_write_MEMWB,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  stall,
  output logic                  mem_err
);

  logic [DATA_W-1:0]     r_alu_res;
  logic [DATA_W-1:0]     r_rs2;
  logic [REG_ADDR_W-1:0] r_write_addr;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_to_reg;

  logic [DATA_W-1:0]     r_wb_data;
  logic [REG_ADDR_W-1:0] r_wb_addr;
  logic                  r_wb_reg_write;

  logic                  w_mem_op;
  logic                  w_misaligned;
  logic                  w_xfer;
  logic                  w_err;
  mem_state_t            w_state;

  assign w_mem_op     = r_mem_read | r_mem_write;
  assign w_misaligned = is_misaligned(r_alu_res[1:0]);
  assign dmem_req     = w_mem_op & (w_state != ERR) & ~w_misaligned;
  assign w_xfer       = dmem_req & dmem_ack;
  assign stall        = (w_mem_op & ~w_xfer) | (w_state == ERR);

  // A set mem_write wins over mem_read, so read+write is issued as a store.
  assign dmem_we    = r_mem_write;
  assign dmem_addr  = r_alu_res;
  assign dmem_wdata = r_rs2;

  // EX/MEM register; register 0 is never marked as a write target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_res    <= '0;
      r_rs2        <= '0;
      r_write_addr <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      r_alu_res    <= alu_res;
      r_rs2        <= RS2_sw;
      r_write_addr <= write_addr_IDEX;
      r_reg_write  <= reg_write_IDEX & (write_addr_IDEX != '0);
      r_mem_read   <= mem_read_IDEX;
      r_mem_write  <= mem_write_IDEX;
      r_mem_to_reg <= mem_to_reg_IDEX;
    end
  end

  // MEM/WB register; a stalled cycle retires a bubble and keeps the old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data      <= '0;
      r_wb_addr      <= '0;
      r_wb_reg_write <= 1'b0;
    end else if (stall) begin
      r_wb_reg_write <= 1'b0;
    end else begin
      r_wb_data      <= (r_mem_to_reg & ~r_mem_write) ? dmem_rdata : r_alu_res;
      r_wb_addr      <= r_write_addr;
      r_wb_reg_write <= r_reg_write;
    end
  end

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .i_mem_op    (w_mem_op),
    .i_misaligned(w_misaligned),
    .i_req       (dmem_req),
    .i_ack       (dmem_ack),
    .o_state     (w_state),
    .o_err       (w_err)
  );

  assign alu_res_EXMEM    = r_alu_res;
  assign write_addr_EXMEM = r_write_addr;
  assign reg_write_EXMEM  = r_reg_write;
  assign write_data       = r_wb_data;
  assign write_addr_MEMWB = r_wb_addr;
  assign reg_write_MEMWB  = r_wb_reg_write;
  assign mem_err          = w_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed corner sequences,
// and a randomized instruction stream checked against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_res, RS2_sw;
  logic [7:0]  write_addr_IDEX;
  logic        reg_write_IDEX, mem_read_IDEX, mem_write_IDEX, mem_to_reg_IDEX;
  logic [31:0] alu_res_EXMEM;
  logic [7:0]  write_addr_EXMEM;
  logic        reg_write_EXMEM;
  logic [31:0] write_data;
  logic [7:0]  write_addr_MEMWB;
  logic        reg_write_MEMWB;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .alu_res(alu_res), .RS2_sw(RS2_sw),
    .write_addr_IDEX(write_addr_IDEX), .reg_write_IDEX(reg_write_IDEX),
    .mem_read_IDEX(mem_read_IDEX), .mem_write_IDEX(mem_write_IDEX),
    .mem_to_reg_IDEX(mem_to_reg_IDEX), .alu_res_EXMEM(alu_res_EXMEM),
    .write_addr_EXMEM(write_addr_EXMEM), .reg_write_EXMEM(reg_write_EXMEM),
    .write_data(write_data), .write_addr_MEMWB(write_addr_MEMWB),
    .reg_write_MEMWB(reg_write_MEMWB), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .mem_err(mem_err)
  );

  // Memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  assign dmem_rdata = mem_model(dmem_addr);

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [7:0]  waddr;
    logic        rw, mr, mw, m2r;
  } instr_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  typedef struct {
    logic [31:0] alu;
    logic [7:0]  waddr;
    logic        rw;
    logic        exp_rw;
  } vec_t;

  instr_t nop = '{32'd0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t x);
    alu_res         = x.alu;
    RS2_sw          = x.rs2;
    write_addr_IDEX = x.waddr;
    reg_write_IDEX  = x.rw;
    mem_read_IDEX   = x.mr;
    mem_write_IDEX  = x.mw;
    mem_to_reg_IDEX = x.m2r;
  endtask

  task automatic do_reset();
    drive(nop);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] rs2,
                                input logic [7:0] wa, input logic rw, input logic mr,
                                input logic mw, input logic m2r);
    instr_t x;
    x.alu = alu; x.rs2 = rs2; x.waddr = wa; x.rw = rw; x.mr = mr; x.mw = mw; x.m2r = m2r;
    return x;
  endfunction

  vec_t   vecs[6];
  instr_t prog[200];
  pair_t  exp_wb[$];
  pair_t  exp_st[$];

  initial begin
    int bubbles, reqs, wcnt, wtgt, cyc, i;
    logic consumed;
    pair_t p;

    dmem_ack = 1'b0;
    do_reset();

    // Reset state
    chk("rst_alu_exmem", alu_res_EXMEM, 32'd0);
    chk("rst_rw_exmem", {31'd0, reg_write_EXMEM}, 32'd0);
    chk("rst_rw_memwb", {31'd0, reg_write_MEMWB}, 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);

    // Non-memory instructions through both registers
    vecs[0] = '{32'h0000_1234, 8'd1,   1'b1, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 8'd255, 1'b1, 1'b1};
    vecs[2] = '{32'hCAFE_0001, 8'd0,   1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 8'd17,  1'b0, 1'b0};
    vecs[4] = '{32'h0000_0003, 8'd42,  1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 8'd0,   1'b0, 1'b0};
    for (int v = 0; v < 6; v++) begin
      drive(mk(vecs[v].alu, 32'h0, vecs[v].waddr, vecs[v].rw, 1'b0, 1'b0, 1'b0));
      tick();
      drive(nop);
      chk($sformatf("vec%0d_exmem_rw", v), {31'd0, reg_write_EXMEM}, {31'd0, vecs[v].exp_rw});
      chk($sformatf("vec%0d_exmem_alu", v), alu_res_EXMEM, vecs[v].alu);
      chk($sformatf("vec%0d_stall", v), {31'd0, stall}, 32'd0);
      tick();
      chk($sformatf("vec%0d_wdata", v), write_data, vecs[v].alu);
      chk($sformatf("vec%0d_waddr", v), {24'd0, write_addr_MEMWB}, {24'd0, vecs[v].waddr});
      chk($sformatf("vec%0d_memwb_rw", v), {31'd0, reg_write_MEMWB}, {31'd0, vecs[v].exp_rw});
    end

    // Load with three wait cycles
    drive(mk(32'h100, 32'h0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    drive(nop);
    chk("ld_req", {31'd0, dmem_req}, 32'd1);
    chk("ld_stall0", {31'd0, stall}, 32'd1);
    bubbles = 0;
    for (int c = 1; c < 3; c++) begin
      tick();
      chk($sformatf("ld_stall%0d", c), {31'd0, stall}, 32'd1);
      if (!reg_write_MEMWB) bubbles++;
    end
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("ld_stall_ack", {31'd0, stall}, 32'd0);
    if (!reg_write_MEMWB) bubbles++;
    tick();
    dmem_ack = 1'b0;
    chk("ld_wdata", write_data, mem_model(32'h100));
    chk("ld_rw", {31'd0, reg_write_MEMWB}, 32'd1);
    chk("ld_waddr", {24'd0, write_addr_MEMWB}, 32'd5);
    chk("ld_bubbles", bubbles, 32'd3);

    // Zero-wait store
    dmem_ack = 1'b1;
    drive(mk(32'h40, 32'hDEADBEEF, 8'd7, 1'b1, 1'b0, 1'b1, 1'b0));
    tick();
    drive(nop);
    chk("st_req", {31'd0, dmem_req}, 32'd1);
    chk("st_we", {31'd0, dmem_we}, 32'd1);
    chk("st_addr", dmem_addr, 32'h40);
    chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("st_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("st_rw", {31'd0, reg_write_MEMWB}, 32'd1);
    chk("st_wbdata", write_data, 32'h40);
    chk("st_stall2", {31'd0, stall}, 32'd0);

    // Back-to-back loads with immediate acks
    drive(mk(32'h200, 32'h0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    drive(mk(32'h204, 32'h0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1));
    chk("b2b_req1", {31'd0, dmem_req}, 32'd1);
    chk("b2b_stall1", {31'd0, stall}, 32'd0);
    tick();
    drive(nop);
    chk("b2b_req2", {31'd0, dmem_req}, 32'd1);
    chk("b2b_addr2", dmem_addr, 32'h204);
    chk("b2b_wb1", write_data, mem_model(32'h200));
    chk("b2b_wa1", {24'd0, write_addr_MEMWB}, 32'd3);
    tick();
    chk("b2b_wb2", write_data, mem_model(32'h204));
    chk("b2b_wa2", {24'd0, write_addr_MEMWB}, 32'd4);
    chk("b2b_rw2", {31'd0, reg_write_MEMWB}, 32'd1);
    chk("b2b_req_done", {31'd0, dmem_req}, 32'd0);
    dmem_ack = 1'b0;

    // Misaligned load
    drive(mk(32'h102, 32'h0, 8'd6, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    drive(nop);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("mis_err", {31'd0, mem_err}, 32'd1);
    chk("mis_stall2", {31'd0, stall}, 32'd1);

    // Timeout after four unacknowledged request cycles
    do_reset();
    chk("to_err_cleared", {31'd0, mem_err}, 32'd0);
    drive(mk(32'h300, 32'h0, 8'd8, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    drive(nop);
    reqs = 0;
    for (int j = 0; j < 4; j++) begin
      if (dmem_req) reqs++;
      chk($sformatf("to_noerr%0d", j), {31'd0, mem_err}, 32'd0);
      tick();
    end
    chk("to_reqs", reqs, 32'd4);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_req_off", {31'd0, dmem_req}, 32'd0);
    dmem_ack = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("to_sticky_err%0d", j), {31'd0, mem_err}, 32'd1);
      chk($sformatf("to_sticky_stall%0d", j), {31'd0, stall}, 32'd1);
    end
    dmem_ack = 1'b0;

    // Reset while waiting, then a late ack
    do_reset();
    drive(mk(32'h500, 32'h0, 8'd9, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    drive(nop);
    tick();
    chk("rw_wait_req", {31'd0, dmem_req}, 32'd1);
    chk("rw_wait_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dmem_ack = 1'b1;
    #1;
    chk("rw_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_memwb_rw", {31'd0, reg_write_MEMWB}, 32'd0);
    chk("rw_err", {31'd0, mem_err}, 32'd0);
    drive(mk(32'h77, 32'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(nop);
    chk("r0_rw_exmem", {31'd0, reg_write_EXMEM}, 32'd0);
    chk("r0_alu_exmem", alu_res_EXMEM, 32'h77);
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("r0_rw_memwb", {31'd0, reg_write_MEMWB}, 32'd0);
    dmem_ack = 1'b0;

    // Randomized instruction stream against a transaction-level model
    do_reset();
    for (int k = 0; k < 200; k++) begin
      instr_t x;
      int kind;
      kind    = $urandom_range(0, 3);
      x.alu   = $urandom;
      x.rs2   = $urandom;
      x.waddr = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      x.rw = 1'b0; x.mr = 1'b0; x.mw = 1'b0; x.m2r = 1'b0;
      if (kind <= 1) begin
        x.rw = 1'($urandom_range(0, 1));
      end else if (kind == 2) begin
        x.alu = x.alu & 32'hFFFF_FFFC;
        x.mr = 1'b1; x.m2r = 1'b1; x.rw = 1'b1;
      end else begin
        x.alu = x.alu & 32'hFFFF_FFFC;
        x.mw = 1'b1;
        x.mr = 1'($urandom_range(0, 1));
        x.m2r = 1'($urandom_range(0, 1));
        x.rw = 1'($urandom_range(0, 1));
      end
      prog[k] = x;
    end
    i = 0; wcnt = 0; wtgt = $urandom_range(0, 2); cyc = 0;
    while ((i < 200 || exp_wb.size() > 0 || exp_st.size() > 0) && cyc < 4000) begin
      if (i < 200) drive(prog[i]); else drive(nop);
      dmem_ack = dmem_req && (wcnt >= wtgt);
      #1;
      if (dmem_req && dmem_ack) begin
        if (dmem_we) begin
          if (exp_st.size() == 0) begin
            chk("rnd_store_unexpected", 32'd1, 32'd0);
          end else begin
            p = exp_st.pop_front();
            chk("rnd_st_addr", dmem_addr, p.a);
            chk("rnd_st_data", dmem_wdata, p.d);
          end
        end
        wcnt = 0;
        wtgt = $urandom_range(0, 2);
      end else if (dmem_req) begin
        wcnt++;
      end
      consumed = !stall && (i < 200);
      @(posedge clk);
      #1;
      if (consumed) begin
        if (prog[i].mw) begin
          p.a = prog[i].alu; p.d = prog[i].rs2;
          exp_st.push_back(p);
        end
        if (prog[i].rw && prog[i].waddr != 8'd0) begin
          p.a = {24'd0, prog[i].waddr};
          p.d = (prog[i].m2r && !prog[i].mw) ? mem_model(prog[i].alu) : prog[i].alu;
          exp_wb.push_back(p);
        end
        i++;
      end
      if (reg_write_MEMWB) begin
        if (exp_wb.size() == 0) begin
          chk("rnd_wb_unexpected", 32'd1, 32'd0);
        end else begin
          p = exp_wb.pop_front();
          chk("rnd_wb_addr", {24'd0, write_addr_MEMWB}, p.a);
          chk("rnd_wb_data", write_data, p.d);
        end
      end
      cyc++;
    end
    dmem_ack = 1'b0;
    chk("rnd_all_issued", i, 32'd200);
    chk("rnd_wb_drained", exp_wb.size(), 32'd0);
    chk("rnd_st_drained", exp_st.size(), 32'd0);
    chk("rnd_no_err", {31'd0, mem_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
